// File: rtl/rv32i_types.sv
// ----------------------------------------------------------------------------
// rv32i_types
//   Shared type package for the instruction-fetch path.
//   Holds the instruction-cache FSM state encoding, line/offset geometry and a
//   helper that selects one 32-bit word out of a 256-bit cache line.
//   No ports (package).
// ----------------------------------------------------------------------------
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        DONE
    } icache_state_t;

    localparam int ICACHE_LINE_BITS   = 256;
    localparam int ICACHE_OFFSET_BITS = 5;

    // Word k of a line lives in bits [32k+31:32k].
    function automatic logic [31:0] icache_word(input logic [ICACHE_LINE_BITS-1:0] line,
                                                input logic [2:0]                  sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/icache_array.sv
// ----------------------------------------------------------------------------
// icache_array
//   Flop-based storage for the direct-mapped instruction cache: one valid bit,
//   one tag and one 256-bit line per set.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (clears valid bits)
//     rd_index_i    combinational read index
//     rd_valid_o    valid bit of the indexed set
//     rd_tag_o      tag of the indexed set
//     rd_line_o     line data of the indexed set
//     we_i          write enable (write happens on the clock edge)
//     wr_index_i    set to write
//     wr_tag_i      tag to store
//     wr_line_i     line to store
// ----------------------------------------------------------------------------
module icache_array
    import rv32i_types::*;
#(
    parameter int NUM_SETS = 16,
    parameter int TAG_BITS = 23,
    localparam int IDX_BITS = $clog2(NUM_SETS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IDX_BITS-1:0]         rd_index_i,
    output logic                        rd_valid_o,
    output logic [TAG_BITS-1:0]         rd_tag_o,
    output logic [ICACHE_LINE_BITS-1:0] rd_line_o,
    input  logic                        we_i,
    input  logic [IDX_BITS-1:0]         wr_index_i,
    input  logic [TAG_BITS-1:0]         wr_tag_i,
    input  logic [ICACHE_LINE_BITS-1:0] wr_line_i
);

    logic [NUM_SETS-1:0]         valid_q;
    logic [TAG_BITS-1:0]         tag_q  [NUM_SETS];
    logic [ICACHE_LINE_BITS-1:0] data_q [NUM_SETS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

    // Only the valid bits need a reset; tag/data are meaningless until valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end
    end

endmodule

// File: rtl/icache.sv
// ----------------------------------------------------------------------------
// icache
//   Direct-mapped, read-only instruction cache. One 32-bit word per fetch
//   request; a hit answers the cycle after the request, a miss fetches a whole
//   256-bit line from the backing memory and then answers.
//   Optional feature: define ICACHE_PERF_EN to add hit/miss counters.
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     ufp_addr     fetch byte address (bits [1:0] ignored)
//     ufp_rmask    nonzero = read request, held until ufp_resp
//     ufp_rdata    instruction word, zero whenever ufp_resp is low
//     ufp_resp     one-cycle response pulse
//     dfp_addr     line-aligned memory address
//     dfp_read     line read request, held until dfp_resp
//     dfp_rdata    line data from memory
//     dfp_resp     one-cycle pulse, line valid this cycle
//     hit_count    LOOKUP hits  (ICACHE_PERF_EN only)
//     miss_count   LOOKUP misses (ICACHE_PERF_EN only)
// ----------------------------------------------------------------------------
module icache
    import rv32i_types::*;
#(
    parameter int NUM_SETS  = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          ufp_addr,
    input  logic [3:0]           ufp_rmask,
    output logic [31:0]          ufp_rdata,
    output logic                 ufp_resp,
    output logic [31:0]          dfp_addr,
    output logic                 dfp_read,
    input  logic [LINE_BITS-1:0] dfp_rdata,
    input  logic                 dfp_resp
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int IDX_BITS = $clog2(NUM_SETS);
    localparam int TAG_BITS = 32 - ICACHE_OFFSET_BITS - IDX_BITS;

    icache_state_t state_q;
    logic [31:2]   addr_q;
    logic          resp_q;
    logic [31:0]   rdata_q;
    logic          dfp_read_q;
    logic [31:0]   dfp_addr_q;

    logic [IDX_BITS-1:0]         req_index;
    logic [TAG_BITS-1:0]         req_tag;
    logic                        rd_valid;
    logic [TAG_BITS-1:0]         rd_tag;
    logic [LINE_BITS-1:0]        rd_line;
    logic                        lookup_hit;
    logic                        fill_we;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^ufp_addr[1:0];

    // The array is probed with the live request address while still IDLE, so
    // the registered hit response is already visible in the LOOKUP cycle.
    assign req_index  = ufp_addr[ICACHE_OFFSET_BITS +: IDX_BITS];
    assign req_tag    = ufp_addr[31 -: TAG_BITS];
    assign lookup_hit = rd_valid && (rd_tag == req_tag);

    // Writes only ever use the latched address, never the live one.
    assign fill_we = (state_q == FILL) && dfp_resp;

    icache_array #(
        .NUM_SETS (NUM_SETS),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (req_index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .we_i       (fill_we),
        .wr_index_i (addr_q[ICACHE_OFFSET_BITS +: IDX_BITS]),
        .wr_tag_i   (addr_q[31 -: TAG_BITS]),
        .wr_line_i  (dfp_rdata)
    );

    // Request FSM. resp/rdata default to zero every cycle and are only raised
    // for the single cycle of a response. In LOOKUP, resp_q doubles as the hit
    // flag computed on acceptance. On a fill the selected word goes straight
    // into rdata_q, which serves as the fill register presented in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            resp_q     <= 1'b0;
            rdata_q    <= '0;
            dfp_read_q <= 1'b0;
            dfp_addr_q <= '0;
        end else begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|ufp_rmask) begin
                        addr_q  <= ufp_addr[31:2];
                        resp_q  <= lookup_hit;
                        rdata_q <= lookup_hit ? icache_word(rd_line, ufp_addr[4:2]) : '0;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (resp_q) begin
                        state_q <= IDLE;
                    end else begin
                        dfp_read_q <= 1'b1;
                        dfp_addr_q <= {addr_q[31:5], 5'b00000};
                        state_q    <= FILL;
                    end
                end
                FILL: begin
                    if (dfp_resp) begin
                        dfp_read_q <= 1'b0;
                        resp_q     <= 1'b1;
                        rdata_q    <= icache_word(dfp_rdata, addr_q[4:2]);
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ufp_resp  = resp_q;
    assign ufp_rdata = rdata_q;
    assign dfp_read  = dfp_read_q;
    assign dfp_addr  = dfp_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // Every request passes through LOOKUP exactly once, so that is where it
    // is classified.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (resp_q) begin
                hit_count_q <= hit_count_q + 32'd1;
            end else begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache.sv
// ----------------------------------------------------------------------------
// tb_icache
//   Directed self-checking bench for icache (NUM_SETS=16). The bench plays
//   both the fetch stage and the backing memory. Counter checks are compiled
//   in when ICACHE_PERF_EN is defined.
// ----------------------------------------------------------------------------
module tb_icache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ufp_addr;
    logic [3:0]   ufp_rmask;
    logic [31:0]  ufp_rdata;
    logic         ufp_resp;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
`ifdef ICACHE_PERF_EN
    logic [31:0]  hitCount;
    logic [31:0]  missCount;
`endif

    int checkCount = 0;
    int passCount  = 0;
    longint lastRespTime = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    icache #(
        .NUM_SETS  (16),
        .LINE_BITS (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ufp_addr   (ufp_addr),
        .ufp_rmask  (ufp_rmask),
        .ufp_rdata  (ufp_rdata),
        .ufp_resp   (ufp_resp),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count  (hitCount),
        .miss_count (missCount)
`endif
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Memory contents model: one fixed word for the cold-miss case, otherwise
    // a pattern derived from the line address and word number.
    function automatic logic [31:0] lineWord(input logic [31:0] base, input int k);
        if (base == 32'h0000_1000 && k == 1) return 32'hDEAD_BEEF;
        return 32'hA500_0000 + base + 32'(k * 4);
    endfunction

    function automatic logic [255:0] lineData(input logic [31:0] base);
        logic [255:0] line;
        line = '0;
        for (int k = 0; k < 8; k++) line[k*32 +: 32] = lineWord(base, k);
        return line;
    endfunction

    // One fetch transaction: present the request in the next cycle, answer
    // dfp_read after 'lat' read cycles, and check the response word, its
    // latency, whether memory was touched and at which address.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input bit expMiss, input int lat);
        int          cycles;
        int          readIdx;
        int          respCycle;
        bit          sawRead;
        bit          gotResp;
        bit          zeroErr;
        logic        readAtResp;
        logic [31:0] firstDfpAddr;
        logic [31:0] gotData;
        logic [31:0] base;
        cycles = 0; readIdx = 0; respCycle = 0;
        sawRead = 0; gotResp = 0; zeroErr = 0; readAtResp = 1'b0;
        firstDfpAddr = '0; gotData = '0;
        base = {addr[31:5], 5'b00000};
        @(posedge clk); #1;
        ufp_addr  = addr;
        ufp_rmask = 4'hF;
        while (!gotResp && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            dfp_resp = 1'b0;
            if (ufp_resp) begin
                gotResp      = 1;
                respCycle    = cycles;
                gotData      = ufp_rdata;
                readAtResp   = dfp_read;
                lastRespTime = $time;
                ufp_rmask    = 4'h0;
            end else begin
                if (ufp_rdata != 32'h0) zeroErr = 1;
                if (dfp_read) begin
                    if (!sawRead) firstDfpAddr = dfp_addr;
                    sawRead = 1;
                    if (readIdx == lat) begin
                        dfp_resp  = 1'b1;
                        dfp_rdata = lineData(dfp_addr);
                    end
                    readIdx++;
                end
            end
        end
        ufp_rmask = 4'h0;
        dfp_resp  = 1'b0;
        checkOutput({tag, " resp"}, 32'(gotResp), 32'd1);
        checkOutput({tag, " rdata"}, gotData, lineWord(base, int'(addr[4:2])));
        checkOutput({tag, " latency"}, 32'(respCycle), expMiss ? 32'(3 + lat) : 32'd1);
        checkOutput({tag, " dfp_read used"}, 32'(sawRead), 32'(expMiss));
        checkOutput({tag, " rdata zero when idle"}, 32'(zeroErr), 32'd0);
        checkOutput({tag, " dfp_read low at resp"}, 32'(readAtResp), 32'd0);
        if (expMiss) checkOutput({tag, " dfp_addr"}, firstDfpAddr, base);
    endtask

    // Hard stop in case something wedges outside the bounded loops.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          seenResp;
        int          waitCycles;
        longint      prevTime;
        logic [31:0] hit0;
        logic [31:0] miss0;
        hit0 = '0; miss0 = '0;
        rst = 1'b1; ufp_addr = '0; ufp_rmask = 4'h0; dfp_rdata = '0; dfp_resp = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset ufp_resp", 32'(ufp_resp), 32'd0);
        checkOutput("reset ufp_rdata", ufp_rdata, 32'd0);
        checkOutput("reset dfp_read", 32'(dfp_read), 32'd0);
        checkOutput("reset dfp_addr", dfp_addr, 32'd0);
`ifdef ICACHE_PERF_EN
        checkOutput("reset hit_count", hitCount, 32'd0);
        checkOutput("reset miss_count", missCount, 32'd0);
`endif
        rst = 1'b0;

        // Cold miss, then a hit in the same line.
        applyStimulus("cold miss 1004", 32'h0000_1004, 1'b1, 5);
        applyStimulus("hit 1010", 32'h0000_1010, 1'b0, 0);

        // Conflict eviction on set 0.
        applyStimulus("conflict 1200", 32'h0000_1200, 1'b1, 2);
`ifdef ICACHE_PERF_EN
        hit0  = hitCount;
        miss0 = missCount;
`endif
        applyStimulus("evicted 1000", 32'h0000_1000, 1'b1, 1);

        // Back-to-back hits across the whole line, two cycles apart.
        prevTime = lastRespTime;
        for (int k = 0; k < 8; k++) begin
            applyStimulus($sformatf("burst word%0d", k), 32'h0000_1000 + 32'(k * 4), 1'b0, 0);
            checkOutput($sformatf("burst spacing %0d", k), 32'(lastRespTime - prevTime),
                        (k == 0) ? 32'd20 : 32'd20);
            prevTime = lastRespTime;
        end
`ifdef ICACHE_PERF_EN
        checkOutput("burst hit delta", hitCount - hit0, 32'd8);
        checkOutput("burst miss delta", missCount - miss0, 32'd1);
`endif

        // Reset in the middle of a fill: no response, late dfp_resp ignored.
        @(posedge clk); #1;
        ufp_addr  = 32'h0000_3040;
        ufp_rmask = 4'hF;
        waitCycles = 0;
        while (!dfp_read && waitCycles < 10) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("rstfill dfp_read seen", 32'(dfp_read), 32'd1);
        @(posedge clk); #1;
        rst       = 1'b1;
        ufp_rmask = 4'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rstfill dfp_read after rst", 32'(dfp_read), 32'd0);
        dfp_resp  = 1'b1;
        dfp_rdata = lineData(32'h0000_3040);
        seenResp = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            dfp_resp = 1'b0;
            if (ufp_resp) seenResp++;
        end
        checkOutput("rstfill no ufp_resp", 32'(seenResp), 32'd0);
        checkOutput("rstfill dfp_read idle", 32'(dfp_read), 32'd0);
        checkOutput("rstfill rdata", ufp_rdata, 32'd0);
`ifdef ICACHE_PERF_EN
        checkOutput("rstfill hit_count", hitCount, 32'd0);
        checkOutput("rstfill miss_count", missCount, 32'd0);
`endif
        applyStimulus("refetch 3040", 32'h0000_3040, 1'b1, 3);

        // Zero-wait memory.
        applyStimulus("zero-wait 4088", 32'h0000_4088, 1'b1, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
